// File: rtl/vga_timing_pkg.sv
// Shared VGA timing types, mode constants and the line/frame geometry helper
// used by the raster timing generator.
package vga_timing_pkg;

    typedef struct packed {
        logic [31:0] total;
        logic [31:0] sync_start;
        logic [31:0] sync_end;    // first count after the sync region
    } span_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } pins_t;

    // 640x480@60, 25.175 MHz pixel clock, both syncs active-low
    localparam int unsigned M640_H_ACTIVE = 640;
    localparam int unsigned M640_H_FP     = 16;
    localparam int unsigned M640_H_SYNC   = 96;
    localparam int unsigned M640_H_BP     = 48;
    localparam int unsigned M640_V_ACTIVE = 480;
    localparam int unsigned M640_V_FP     = 10;
    localparam int unsigned M640_V_SYNC   = 2;
    localparam int unsigned M640_V_BP     = 33;
    localparam bit          M640_HS_POL   = 1'b0;
    localparam bit          M640_VS_POL   = 1'b0;

    // 800x600@60, 40 MHz pixel clock, both syncs active-high
    localparam int unsigned M800_H_ACTIVE = 800;
    localparam int unsigned M800_H_FP     = 40;
    localparam int unsigned M800_H_SYNC   = 128;
    localparam int unsigned M800_H_BP     = 88;
    localparam int unsigned M800_V_ACTIVE = 600;
    localparam int unsigned M800_V_FP     = 1;
    localparam int unsigned M800_V_SYNC   = 4;
    localparam int unsigned M800_V_BP     = 23;
    localparam bit          M800_HS_POL   = 1'b1;
    localparam bit          M800_VS_POL   = 1'b1;

    function automatic span_t calc_span(input int unsigned act, input int unsigned fp,
                                        input int unsigned sync, input int unsigned bp);
        span_t s;
        s.total      = act + fp + sync + bp;
        s.sync_start = act + fp;
        s.sync_end   = act + fp + sync;
        return s;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-qualified shift register that keeps the sync/blank pins aligned with
// a multi-cycle colour pipeline. DEPTH = 0 is a straight wire.
module vga_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ctl;
            assign unused_ctl = &{1'b0, clk, reset, en, rst_val};
            assign dout = din;
        end else begin : g_stages
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= rst_val;
                end else if (en) begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel/line counters, zero-latency
// coordinate decodes and sync/blank pins with an optional alignment delay.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int SYNC_DELAY = 0,
    parameter int CW         = 10
) (
    input  logic          VGA_CLK2,
    input  logic          reset,
    input  logic          pix_ce,
    output logic [CW-1:0] h_count,
    output logic [CW-1:0] v_count,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          active,
    output logic          line_start,
    output logic          frame_start,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_BLANK_N,
    output logic          VGA_SYNC_N
);

    localparam span_t         H_SPAN = calc_span(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam span_t         V_SPAN = calc_span(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [CW-1:0] H_LAST = CW'(H_SPAN.total - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_SPAN.total - 1);
    localparam logic [31:0]   H_ACT  = 32'(H_ACTIVE);
    localparam logic [31:0]   V_ACT  = 32'(V_ACTIVE);

    generate
        if ((H_SPAN.total > 2**CW) || (V_SPAN.total > 2**CW)) begin : g_bad_cw
            $error("vga_timing_gen: CW too small for H_TOTAL/V_TOTAL");
        end
        if ((SYNC_DELAY < 0) || (SYNC_DELAY > 7)) begin : g_bad_delay
            $error("vga_timing_gen: SYNC_DELAY must be 0..7");
        end
    endgenerate

    // pix_ce is a one-cycle qualifier: every register in this block, the delay
    // line included, moves only on an edge where pix_ce is 1; reset overrides it.
    always_ff @(posedge VGA_CLK2) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
        end else if (pix_ce) begin
            if (h_count == H_LAST) begin
                h_count <= '0;
                v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
            end else begin
                h_count <= h_count + 1'b1;
            end
        end
    end

    logic  h_act, v_act, h_sync, v_sync;
    pins_t rst_pins, raw_pins, dly_pins;

    always_comb begin
        h_act       = 32'(h_count) < H_ACT;
        v_act       = 32'(v_count) < V_ACT;
        h_sync      = (32'(h_count) >= H_SPAN.sync_start) && (32'(h_count) < H_SPAN.sync_end);
        v_sync      = (32'(v_count) >= V_SPAN.sync_start) && (32'(v_count) < V_SPAN.sync_end);
        active      = h_act && v_act;
        x           = active ? h_count : '0;
        y           = active ? v_count : '0;
        line_start  = (h_count == '0) && pix_ce;
        frame_start = line_start && (v_count == '0);
    end

    // Pins read as deasserted while reset is held, so nothing leaks out of
    // the undelayed path before the counters settle.
    always_comb begin
        rst_pins = '{hs: ~HS_POL, vs: ~VS_POL, blank_n: 1'b0};
        raw_pins = rst_pins;
        if (!reset) begin
            raw_pins.hs      = h_sync ? HS_POL : ~HS_POL;
            raw_pins.vs      = v_sync ? VS_POL : ~VS_POL;
            raw_pins.blank_n = active;
        end
    end

    vga_delay_line #(
        .WIDTH($bits(pins_t)),
        .DEPTH(SYNC_DELAY)
    ) u_delay (
        .clk    (VGA_CLK2),
        .reset  (reset),
        .en     (pix_ce),
        .rst_val(rst_pins),
        .din    (raw_pins),
        .dout   (dly_pins)
    );

    assign VGA_HS      = dly_pins.hs;
    assign VGA_VS      = dly_pins.vs;
    assign VGA_BLANK_N = dly_pins.blank_n;
    assign VGA_SYNC_N  = 1'b1;

endmodule
